// File: rtl/armleocpu_decode_queue.sv
// armleocpu_decode_queue: decode stage between fetch and execute.
// Buffers up to DEPTH fetched instructions and issues them from the FIFO head.
// The issue strobes the register-file reads. Issue stalls for one cycle on a
// read-after-write match with the instruction retiring in execute.
// Execute flush/branch commands are forwarded to fetch, and all buffered work is dropped.
// Optional feature macro: ARMLEOCPU_DECODE_RS_USAGE_EN.
//   - Defined: rs1/rs2 usage is decoded from the opcode.
//   - Undefined: every instruction is treated as reading both source registers.

`ifndef ARMLEOCPU_E2D_CMD_WIDTH
`define ARMLEOCPU_E2D_CMD_WIDTH 2
`endif
`ifndef ARMLEOCPU_E2D_CMD_NONE
`define ARMLEOCPU_E2D_CMD_NONE 2'd0
`endif
`ifndef ARMLEOCPU_E2D_CMD_FLUSH
`define ARMLEOCPU_E2D_CMD_FLUSH 2'd1
`endif
`ifndef ARMLEOCPU_E2D_CMD_START_BRANCH
`define ARMLEOCPU_E2D_CMD_START_BRANCH 2'd2
`endif
`ifndef ARMLEOCPU_D2F_CMD_WIDTH
`define ARMLEOCPU_D2F_CMD_WIDTH 2
`endif
`ifndef ARMLEOCPU_D2F_CMD_NONE
`define ARMLEOCPU_D2F_CMD_NONE 2'd0
`endif
`ifndef ARMLEOCPU_D2F_CMD_FLUSH
`define ARMLEOCPU_D2F_CMD_FLUSH 2'd1
`endif
`ifndef ARMLEOCPU_D2F_CMD_START_BRANCH
`define ARMLEOCPU_D2F_CMD_START_BRANCH 2'd2
`endif

module armleocpu_decode_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                                clk,
    input  logic                                rst_n,

    output logic                                dbg_pipeline_busy,
    output logic [CW-1:0]                       dbg_queue_count,

    output logic                                rs1_read,
    output logic [4:0]                          rs1_raddr,
    output logic                                rs2_read,
    output logic [4:0]                          rs2_raddr,

    output logic                                d2e_valid,
    output logic [31:0]                         d2e_instr,
    output logic [31:0]                         d2e_pc,
    output logic [3:0]                          d2e_resp,

    input  logic                                e2d_ready,
    input  logic [`ARMLEOCPU_E2D_CMD_WIDTH-1:0] e2d_cmd,
    input  logic [31:0]                         e2d_branchtarget,
    input  logic                                e2d_rd_write,
    input  logic [4:0]                          e2d_rd_waddr,

    input  logic                                f2d_valid,
    input  logic [31:0]                         f2d_instr,
    input  logic [31:0]                         f2d_pc,
    input  logic [3:0]                          f2d_resp,
    output logic                                d2f_ready,
    output logic [`ARMLEOCPU_D2F_CMD_WIDTH-1:0] d2f_cmd,
    output logic [31:0]                         d2f_branchtarget
);

    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int D2F_W = `ARMLEOCPU_D2F_CMD_WIDTH;

    logic [31:0]    instr_mem [DEPTH];
    logic [31:0]    pc_mem    [DEPTH];
    logic [3:0]     resp_mem  [DEPTH];

    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic           d2e_valid_reg;
    logic [31:0]    d2e_instr_reg;
    logic [31:0]    d2e_pc_reg;
    logic [3:0]     d2e_resp_reg;

    logic           empty;
    logic           full;
    logic           cmd_active;
    logic           push;
    logic           issue;
    logic           hazard;
    logic [31:0]    head_instr;
    logic           rs1_used;
    logic           rs2_used;

    assign empty      = (count_reg == '0);
    assign full       = (count_reg == CW'(DEPTH));
    // Reset masks the command path so fetch sees NONE while rst_n is low.
    assign cmd_active = rst_n && e2d_ready && (e2d_cmd != `ARMLEOCPU_E2D_CMD_NONE);
    assign d2f_ready  = rst_n && (cmd_active || !full);
    assign push       = f2d_valid && d2f_ready && !cmd_active;

    // The head reads as zero when empty, so register addresses idle at x0.
    assign head_instr = empty ? 32'd0 : instr_mem[rd_ptr_reg];
    assign rs1_raddr  = head_instr[19:15];
    assign rs2_raddr  = head_instr[24:20];

    // Source-register usage of the head instruction.
    always_comb begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
`ifdef ARMLEOCPU_DECODE_RS_USAGE_EN
        // LUI, AUIPC and JAL have no rs1. Only OP, STORE, BRANCH and AMO read rs2.
        rs1_used = !(head_instr[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
        rs2_used =   head_instr[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011, 7'b0101111};
`endif
    end

    // The register file commits the retiring write on this edge, so a matching read stalls one cycle.
    assign hazard = e2d_ready && e2d_rd_write && (e2d_rd_waddr != 5'd0) &&
                    (((e2d_rd_waddr == rs1_raddr) && rs1_used) ||
                     ((e2d_rd_waddr == rs2_raddr) && rs2_used));

    assign issue = rst_n && !empty && (!d2e_valid_reg || e2d_ready) && !hazard && !cmd_active;

    assign rs1_read = issue && rs1_used;
    assign rs2_read = issue && rs2_used;

    assign d2f_cmd          = cmd_active ? D2F_W'(e2d_cmd) : `ARMLEOCPU_D2F_CMD_NONE;
    assign d2f_branchtarget = e2d_branchtarget;

    assign d2e_valid         = d2e_valid_reg;
    assign d2e_instr         = d2e_instr_reg;
    assign d2e_pc            = d2e_pc_reg;
    assign d2e_resp          = d2e_resp_reg;
    assign dbg_queue_count   = count_reg;
    assign dbg_pipeline_busy = !empty || d2e_valid_reg;

    // FIFO storage write. There is no reset because occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_reg] <= f2d_instr;
            pc_mem[wr_ptr_reg]    <= f2d_pc;
            resp_mem[wr_ptr_reg]  <= f2d_resp;
        end
    end

    // Pointers, occupancy and the d2e issue slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            d2e_valid_reg <= 1'b0;
            d2e_instr_reg <= 32'd0;
            d2e_pc_reg    <= 32'd0;
            d2e_resp_reg  <= 4'd0;
        end else if (cmd_active) begin
            // A flush or branch discards everything buffered, including the offered beat.
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            d2e_valid_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (issue) begin
                rd_ptr_reg    <= rd_ptr_reg + PW'(1);
                d2e_valid_reg <= 1'b1;
                d2e_instr_reg <= instr_mem[rd_ptr_reg];
                d2e_pc_reg    <= pc_mem[rd_ptr_reg];
                d2e_resp_reg  <= resp_mem[rd_ptr_reg];
            end else if (e2d_ready) begin
                d2e_valid_reg <= 1'b0;
            end
            if (push && !issue) begin
                count_reg <= count_reg + CW'(1);
            end else if (issue && !push) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_armleocpu_decode_queue.sv
// Self-checking bench for armleocpu_decode_queue.
// A queue-based reference model is checked against the DUT every cycle.
// Directed scenarios add literal checks that pin the model itself.

`ifndef ARMLEOCPU_E2D_CMD_WIDTH
`define ARMLEOCPU_E2D_CMD_WIDTH 2
`endif
`ifndef ARMLEOCPU_D2F_CMD_WIDTH
`define ARMLEOCPU_D2F_CMD_WIDTH 2
`endif
`ifndef ARMLEOCPU_E2D_CMD_NONE
`define ARMLEOCPU_E2D_CMD_NONE 2'd0
`endif
`ifndef ARMLEOCPU_D2F_CMD_NONE
`define ARMLEOCPU_D2F_CMD_NONE 2'd0
`endif

module tb_armleocpu_decode_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                                clk;
    logic                                rst_n;
    logic                                dbg_pipeline_busy;
    logic [CW-1:0]                       dbg_queue_count;
    logic                                rs1_read, rs2_read;
    logic [4:0]                          rs1_raddr, rs2_raddr;
    logic                                d2e_valid;
    logic [31:0]                         d2e_instr, d2e_pc;
    logic [3:0]                          d2e_resp;
    logic                                e2d_ready;
    logic [`ARMLEOCPU_E2D_CMD_WIDTH-1:0] e2d_cmd;
    logic [31:0]                         e2d_branchtarget;
    logic                                e2d_rd_write;
    logic [4:0]                          e2d_rd_waddr;
    logic                                f2d_valid;
    logic [31:0]                         f2d_instr, f2d_pc;
    logic [3:0]                          f2d_resp;
    logic                                d2f_ready;
    logic [`ARMLEOCPU_D2F_CMD_WIDTH-1:0] d2f_cmd;
    logic [31:0]                         d2f_branchtarget;

    int errors = 0;
    int checks = 0;

    armleocpu_decode_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .dbg_pipeline_busy(dbg_pipeline_busy), .dbg_queue_count(dbg_queue_count),
        .rs1_read(rs1_read), .rs1_raddr(rs1_raddr),
        .rs2_read(rs2_read), .rs2_raddr(rs2_raddr),
        .d2e_valid(d2e_valid), .d2e_instr(d2e_instr), .d2e_pc(d2e_pc), .d2e_resp(d2e_resp),
        .e2d_ready(e2d_ready), .e2d_cmd(e2d_cmd), .e2d_branchtarget(e2d_branchtarget),
        .e2d_rd_write(e2d_rd_write), .e2d_rd_waddr(e2d_rd_waddr),
        .f2d_valid(f2d_valid), .f2d_instr(f2d_instr), .f2d_pc(f2d_pc), .f2d_resp(f2d_resp),
        .d2f_ready(d2f_ready), .d2f_cmd(d2f_cmd), .d2f_branchtarget(d2f_branchtarget)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  resp;
    } entry_t;

    entry_t q[$];
    entry_t slot;
    bit     slot_v   = 0;
    bit     model_ok = 0;

    function automatic logic [1:0] rs_use(input logic [31:0] ins);
        logic [6:0] op;
        logic u1, u2;
        op = ins[6:0];
        u1 = 1'b1;
        u2 = 1'b1;
`ifdef ARMLEOCPU_DECODE_RS_USAGE_EN
        u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63 || op == 7'h2F);
`endif
        return {u2, u1};
    endfunction

    always @(negedge clk) begin : model
        logic        cmd, rdy, hz, iss;
        logic [31:0] hi;
        logic [1:0]  use_m;
        int          n;
        n     = q.size();
        cmd   = rst_n && e2d_ready && (e2d_cmd != 0);
        rdy   = rst_n && (cmd || n < DEPTH);
        hi    = (n > 0) ? q[0].instr : 32'd0;
        use_m = rs_use(hi);
        hz    = e2d_ready && e2d_rd_write && e2d_rd_waddr != 0 &&
                ((e2d_rd_waddr == hi[19:15] && use_m[0]) || (e2d_rd_waddr == hi[24:20] && use_m[1]));
        iss   = rst_n && n > 0 && (!slot_v || e2d_ready) && !hz && !cmd;
        if (model_ok) begin
            chk("m_d2f_ready", d2f_ready, rdy);
            chk("m_d2f_cmd", d2f_cmd, cmd ? e2d_cmd : 0);
            chk("m_d2f_target", d2f_branchtarget, e2d_branchtarget);
            chk("m_rs1_raddr", rs1_raddr, hi[19:15]);
            chk("m_rs2_raddr", rs2_raddr, hi[24:20]);
            chk("m_rs1_read", rs1_read, iss && use_m[0]);
            chk("m_rs2_read", rs2_read, iss && use_m[1]);
            chk("m_count", dbg_queue_count, n);
            chk("m_d2e_valid", d2e_valid, slot_v);
            chk("m_d2e_instr", d2e_instr, slot.instr);
            chk("m_d2e_pc", d2e_pc, slot.pc);
            chk("m_d2e_resp", d2e_resp, slot.resp);
            chk("m_busy", dbg_pipeline_busy, (n > 0) || slot_v);
        end
        if (!rst_n) begin
            q.delete();
            slot     = '0;
            slot_v   = 0;
            model_ok = 1;
        end else if (cmd) begin
            q.delete();
            slot_v = 0;
        end else begin
            if (iss) begin
                slot   = q.pop_front();
                slot_v = 1;
                $display("issue pc=%h instr=%h resp=%h", slot.pc, slot.instr, slot.resp);
            end else if (e2d_ready) begin
                slot_v = 0;
            end
            if (f2d_valid && rdy) q.push_back('{f2d_instr, f2d_pc, f2d_resp});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] ins, input logic [31:0] pc, input logic [3:0] resp);
        f2d_valid = 1'b1;
        f2d_instr = ins;
        f2d_pc    = pc;
        f2d_resp  = resp;
    endtask

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction

    localparam logic [31:0] ADD_X3_X1_X2 = 32'h002081B3;
    localparam logic [31:0] LUI_X1_8     = 32'h000080B7;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int j;
        rst_n = 0; e2d_ready = 0; e2d_cmd = 0; e2d_branchtarget = 32'h1234_5678;
        e2d_rd_write = 0; e2d_rd_waddr = 0;
        f2d_valid = 1; f2d_instr = 32'hFFFF_FFFF; f2d_pc = 32'hFFFF_FFF0; f2d_resp = 4'hF;
        @(posedge clk);
        mid();
        chk("rst_d2f_ready", d2f_ready, 0);
        chk("rst_rs1_read", rs1_read, 0);
        tick();
        mid();
        chk("rst_valid", d2e_valid, 0);
        chk("rst_count", dbg_queue_count, 0);
        chk("rst_instr", d2e_instr, 0);
        tick();
        rst_n = 1; f2d_valid = 0;

        // Streaming: first issue two cycles after accept, then one per cycle
        e2d_ready = 1;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) beat(addi(5, 1, i), 32'(i * 4), 4'(i));
            else f2d_valid = 0;
            mid();
            if (i < 2) chk("t1_valid_early", d2e_valid, 0);
            else if (i < 10) begin
                chk("t1_valid", d2e_valid, 1);
                chk("t1_pc", d2e_pc, 32'((i - 2) * 4));
            end else chk("t1_drain", d2e_valid, 0);
            tick();
        end

        // Fill with execute stalled
        e2d_ready = 0; j = 0;
        for (int c = 0; c < 8; c++) begin
            beat(addi(6, 2, j), 32'(32'h100 + j * 4), 4'h1);
            mid();
            if (d2f_ready) j++;
            tick();
        end
        mid();
        chk("t2_accepted", 32'(j), 5);
        chk("t2_count", dbg_queue_count, 4);
        chk("t2_valid", d2e_valid, 1);
        chk("t2_pc", d2e_pc, 32'h100);
        chk("t2_ready_full", d2f_ready, 0);
        tick();
        e2d_ready = 1; e2d_cmd = 1;
        mid();
        chk("t2_flush_cmd", d2f_cmd, 1);
        chk("t2_flush_ready", d2f_ready, 1);
        tick();
        e2d_cmd = 0; f2d_valid = 0;
        mid();
        chk("t2_flush_count", dbg_queue_count, 0);
        chk("t2_flush_valid", d2e_valid, 0);
        tick();

        // RAW hazard on rs1, then write to x0 which never stalls
        beat(ADD_X3_X1_X2, 32'h200, 4'h2);
        mid(); tick();
        f2d_valid = 0; e2d_rd_write = 1; e2d_rd_waddr = 1;
        mid();
        chk("t3_stall_rs1", rs1_read, 0);
        chk("t3_stall_rs2", rs2_read, 0);
        chk("t3_raddr1", rs1_raddr, 1);
        chk("t3_raddr2", rs2_raddr, 2);
        tick();
        e2d_rd_write = 0;
        mid();
        chk("t3_issue_rs1", rs1_read, 1);
        chk("t3_issue_rs2", rs2_read, 1);
        tick();
        mid();
        chk("t3_valid", d2e_valid, 1);
        chk("t3_pc", d2e_pc, 32'h200);
        tick();
        beat(ADD_X3_X1_X2, 32'h204, 4'h3);
        mid(); tick();
        f2d_valid = 0; e2d_rd_write = 1; e2d_rd_waddr = 0;
        mid();
        chk("t3_x0_rs1", rs1_read, 1);
        tick();
        e2d_rd_write = 0;
        mid();
        chk("t3_x0_pc", d2e_pc, 32'h204);
        chk("t3_x0_valid", d2e_valid, 1);
        tick();

        // Branch command with 3 buffered entries and a beat offered
        e2d_ready = 0;
        for (int k = 0; k < 4; k++) begin
            beat(addi(7, 3, k), 32'(32'h300 + k * 4), 4'h4);
            mid();
            chk("t4_accept", d2f_ready, 1);
            tick();
        end
        f2d_valid = 0;
        mid();
        chk("t4_count3", dbg_queue_count, 3);
        tick();
        e2d_ready = 1; e2d_cmd = 2; e2d_branchtarget = 32'h8000_0000;
        beat(addi(9, 9, 9), 32'h999C, 4'h9);
        mid();
        chk("t4_ready", d2f_ready, 1);
        chk("t4_cmd", d2f_cmd, 2);
        chk("t4_target", d2f_branchtarget, 32'h8000_0000);
        tick();
        e2d_cmd = 0; f2d_valid = 0;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("t4_no_issue", d2e_valid, 0);
            chk("t4_count0", dbg_queue_count, 0);
            tick();
        end

        // LUI x1 against a write to x1
        beat(LUI_X1_8, 32'h400, 4'h5);
        mid(); tick();
        f2d_valid = 0; e2d_rd_write = 1; e2d_rd_waddr = 1;
        mid();
        chk("t5_rs1_read", rs1_read, 0);
        chk("t5_rs2_read", rs2_read, 0);
        tick();
        e2d_rd_write = 0;
        mid();
`ifdef ARMLEOCPU_DECODE_RS_USAGE_EN
        chk("t5_nostall_valid", d2e_valid, 1);
        chk("t5_nostall_pc", d2e_pc, 32'h400);
`else
        chk("t5_stall_valid", d2e_valid, 0);
        chk("t5_late_rs1", rs1_read, 1);
`endif
        tick();
        mid(); tick();
        mid(); tick();

        // Reset mid-operation
        e2d_ready = 0;
        for (int k = 0; k < 3; k++) begin
            beat(addi(8, 4, k), 32'(32'h500 + k * 4), 4'h6);
            mid(); tick();
        end
        rst_n = 0; e2d_ready = 1; e2d_cmd = 1;
        mid();
        chk("t6_pre_count", dbg_queue_count, 2);
        chk("t6_pre_valid", d2e_valid, 1);
        chk("t6_rst_ready", d2f_ready, 0);
        chk("t6_rst_rs1", rs1_read, 0);
        chk("t6_rst_cmd", d2f_cmd, 0);
        tick();
        rst_n = 1; e2d_cmd = 0; f2d_valid = 0;
        mid();
        chk("t6_valid", d2e_valid, 0);
        chk("t6_count", dbg_queue_count, 0);
        chk("t6_pc", d2e_pc, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
